// File: rtl/fetch_prefetch_unit_if.sv
// Signal bundle between the fetch unit and its environment: program load,
// branch redirect from execute, and the decode-facing instruction outputs.
interface fetch_prefetch_unit_if;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        flush_out;

  modport master (
    output load_we, load_addr, load_data, redirect_valid, redirect_target, stall,
    input  inst_out, pc_out, inst_valid, flush_out
  );

  modport slave (
    input  load_we, load_addr, load_data, redirect_valid, redirect_target, stall,
    output inst_out, pc_out, inst_valid, flush_out
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: PC, synchronous-read instruction memory and a
// credit-controlled prefetch queue of {pc, instruction} pairs feeding decode.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_prefetch_unit_if.slave bus
);
  localparam int unsigned AW  = $clog2(IMEM_WORDS);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr[AW+1:2];
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_mem    [IMEM_WORDS];
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic          r_flush;

  logic          r_vld_p1;
  logic [31:0]   r_inst_p1;
  logic [31:0]   r_pc_p1;

  logic          w_redirect;
  logic          w_clear;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_restart;
  logic          w_empty;
  logic [CW-1:0] w_occ;

  assign w_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load beats redirect, redirect beats pop/push/issue.
  always_comb begin
    w_state_nxt = r_state;
    w_redirect  = 1'b0;
    w_clear     = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_issue     = 1'b0;
    w_restart   = 1'b0;
    w_occ       = r_count + CW'(r_vld_p1);
    if (bus.load_we) begin
      w_state_nxt = S_LOAD;
      w_clear     = 1'b1;
    end else if (r_state == S_LOAD) begin
      w_state_nxt = S_RUN;
      w_restart   = 1'b1;
    end else if (bus.redirect_valid) begin
      w_redirect = 1'b1;
      w_clear    = 1'b1;
    end else begin
      w_pop   = !w_empty && !bus.stall;
      w_push  = r_vld_p1;
      w_issue = (w_occ - CW'(w_pop)) < CW'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_vld_p1   <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_flush  <= w_redirect;
      r_vld_p1 <= w_issue;
      if (w_clear) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      if (w_redirect) begin
        r_fetch_pc <= bus.redirect_target & ~32'h3;
      end else if (w_restart) begin
        r_fetch_pc <= RESET_PC;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  // Stage p0 -> p1: memory read of the issued PC; p1 -> queue: push on return.
  always_ff @(posedge clk) begin
    if (bus.load_we && !rst) begin
      r_mem[word_idx(bus.load_addr)] <= bus.load_data;
    end
    if (w_issue) begin
      r_inst_p1 <= r_mem[word_idx(r_fetch_pc)];
      r_pc_p1   <= r_fetch_pc;
    end
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= r_inst_p1;
      r_q_pc[r_wr_ptr]   <= r_pc_p1;
    end
  end

  assign bus.inst_valid = !w_empty;
  assign bus.inst_out   = w_empty ? NOP   : r_q_inst[r_rd_ptr];
  assign bus.pc_out     = w_empty ? 32'h0 : r_q_pc[r_rd_ptr];
  assign bus.flush_out  = r_flush;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based behavioural model.
module tb_fetch_prefetch_unit;
  localparam int          DEPTH      = 4;
  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus ();

  fetch_prefetch_unit #(
    .DEPTH      (DEPTH),
    .IMEM_WORDS (IMEM_WORDS),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model state
  entry_t      m_q[$];
  entry_t      m_pend;
  bit          m_pend_v;
  logic [31:0] m_mem [IMEM_WORDS];
  logic [31:0] m_pc;
  bit          m_loading;
  bit          m_flush;
  bit          m_known = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int     first_valid;
  bit     found;
  int     lw_left;
  entry_t seen[$];
  logic [31:0] prog [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] byte_addr);
    return int'((byte_addr >> 2) % IMEM_WORDS);
  endfunction

  task automatic model_step(input bit r, input bit lw, input logic [31:0] la,
                            input logic [31:0] ld, input bit rv, input logic [31:0] rt,
                            input bit st);
    if (r) begin
      m_q.delete();
      m_pend_v  = 1'b0;
      m_pc      = RESET_PC;
      m_loading = 1'b0;
      m_flush   = 1'b0;
      m_known   = 1'b1;
    end else begin
      m_flush = 1'b0;
      if (lw) begin
        m_mem[midx(la)] = ld;
        m_q.delete();
        m_pend_v  = 1'b0;
        m_loading = 1'b1;
      end else if (m_loading) begin
        m_loading = 1'b0;
        m_pc      = RESET_PC;
      end else if (rv) begin
        m_q.delete();
        m_pend_v = 1'b0;
        m_pc     = rt & ~32'h3;
        m_flush  = 1'b1;
      end else begin
        if (m_q.size() > 0 && !st) void'(m_q.pop_front());
        if (m_pend_v) m_q.push_back(m_pend);
        // A new fetch is allowed only if its word is guaranteed a queue slot.
        if (m_q.size() < DEPTH) begin
          m_pend.pc   = m_pc;
          m_pend.inst = m_mem[midx(m_pc)];
          m_pend_v    = 1'b1;
          m_pc        = m_pc + 32'd4;
        end else begin
          m_pend_v = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                       input bit rv, input logic [31:0] rt, input bit st);
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    @(negedge clk);
    if (m_known) begin
      e_pc   = (m_q.size() != 0) ? m_q[0].pc   : 32'h0;
      e_inst = (m_q.size() != 0) ? m_q[0].inst : NOP;
      check_eq("inst_valid", 32'(bus.inst_valid), 32'(m_q.size() != 0));
      check_eq("pc_out", bus.pc_out, e_pc);
      check_eq("inst_out", bus.inst_out, e_inst);
      check_eq("flush_out", 32'(bus.flush_out), 32'(m_flush));
    end
    rst                 = r;
    bus.load_we         = lw;
    bus.load_addr       = la;
    bus.load_data       = ld;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.stall           = st;
    @(posedge clk);
    model_step(r, lw, la, ld, rv, rt, st);
  endtask

  task automatic run(input bit st);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, st);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic redir(input logic [31:0] target);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, target, 1'b0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.load_we         = 1'b0;
    bus.load_addr       = 32'h0;
    bus.load_data       = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.stall           = 1'b0;
    prog[0] = 32'h0010_0093;
    prog[1] = 32'h0020_0113;
    prog[2] = 32'h0030_8193;
    prog[3] = 32'h0040_0213;

    do_reset();
    do_reset();
    #1;
    check_eq("rst_valid", 32'(bus.inst_valid), 32'h0);
    check_eq("rst_inst", bus.inst_out, NOP);
    check_eq("rst_pc", bus.pc_out, 32'h0);

    // Program load: known words at 0..3, random fill elsewhere.
    for (int i = 0; i < IMEM_WORDS; i++) begin
      cycle(1'b0, 1'b1, 32'(i * 4), (i < 4) ? prog[i] : $urandom, 1'b0, 32'h0, 1'b0);
    end
    first_valid = -1;
    seen.delete();
    for (int k = 0; k < 12; k++) begin
      run(1'b0);
      #1;
      if (bus.inst_valid) begin
        if (first_valid < 0) first_valid = k;
        seen.push_back({bus.pc_out, bus.inst_out});
      end
    end
    check_eq("first_valid_latency", 32'(first_valid), 32'd2);
    for (int k = 0; k < 4; k++) begin
      check_eq("run_pc", seen[k].pc, 32'(k * 4));
      check_eq("run_inst", seen[k].inst, prog[k]);
    end

    // Stall fill then drain.
    do_reset();
    for (int k = 0; k < 10; k++) run(1'b1);
    #1;
    check_eq("fill_valid", 32'(bus.inst_valid), 32'h1);
    check_eq("fill_pc", bus.pc_out, 32'h0);
    check_eq("fill_inst", bus.inst_out, prog[0]);
    for (int k = 0; k < 8; k++) begin
      run(1'b0);
      #1;
      check_eq("drain_valid", 32'(bus.inst_valid), 32'h1);
      check_eq("drain_pc", bus.pc_out, 32'((k + 1) * 4));
    end

    // Redirect while head is pc 8, with pop and in-flight read.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run(1'b0);
      #1;
      if (bus.inst_valid && bus.pc_out == 32'h8) found = 1'b1;
    end
    check_eq("found_pc8", 32'(found), 32'h1);
    redir(32'h0000_0042);
    #1;
    check_eq("redir_flush", 32'(bus.flush_out), 32'h1);
    check_eq("redir_valid0", 32'(bus.inst_valid), 32'h0);
    run(1'b0);
    #1;
    check_eq("redir_flush_off", 32'(bus.flush_out), 32'h0);
    check_eq("redir_valid1", 32'(bus.inst_valid), 32'h0);
    run(1'b0);
    #1;
    check_eq("redir_tgt_valid", 32'(bus.inst_valid), 32'h1);
    check_eq("redir_tgt_pc", bus.pc_out, 32'h40);
    check_eq("redir_tgt_inst", bus.inst_out, m_mem[16]);
    for (int k = 1; k < 5; k++) begin
      run(1'b0);
      #1;
      check_eq("post_flush_pc", bus.pc_out, 32'(32'h40 + k * 4));
    end

    // Memory index wrap.
    redir(32'h0000_03FC);
    run(1'b0);
    run(1'b0);
    #1;
    check_eq("wrap_pc0", bus.pc_out, 32'h3FC);
    check_eq("wrap_inst0", bus.inst_out, m_mem[255]);
    run(1'b0);
    #1;
    check_eq("wrap_pc1", bus.pc_out, 32'h400);
    check_eq("wrap_inst1", bus.inst_out, m_mem[0]);

    // Load pulse mid-run, then reset with a full queue.
    for (int k = 0; k < 6; k++) run(1'b0);
    cycle(1'b0, 1'b1, 32'h40, $urandom, 1'b1, 32'h80, 1'b0);
    #1;
    check_eq("load_empty", 32'(bus.inst_valid), 32'h0);
    check_eq("load_noflush", 32'(bus.flush_out), 32'h0);
    for (int k = 0; k < 3; k++) run(1'b0);
    #1;
    check_eq("load_restart_valid", 32'(bus.inst_valid), 32'h1);
    check_eq("load_restart_pc", bus.pc_out, RESET_PC);
    for (int k = 0; k < 10; k++) run(1'b1);
    do_reset();
    #1;
    check_eq("rst_full_valid", 32'(bus.inst_valid), 32'h0);
    run(1'b0);
    run(1'b0);
    #1;
    check_eq("rst_refetch_pc", bus.pc_out, RESET_PC);

    // Random traffic against the model.
    lw_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          lw;
      bit          rv;
      bit          st;
      logic [31:0] rt;
      r = ($urandom_range(0, 199) == 0);
      if (lw_left == 0 && $urandom_range(0, 99) == 0) lw_left = int'($urandom_range(1, 4));
      lw = (lw_left > 0);
      if (lw_left > 0) lw_left--;
      rv = ($urandom_range(0, 19) == 0);
      rt = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
      st = ($urandom_range(0, 2) == 0);
      cycle(r, lw, $urandom, $urandom, rv, rt, st);
    end
    run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
